// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter (core vs. external requester).
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W       = 12;
    localparam int unsigned DEF_WORD_W       = 16;
    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned DEF_STARVE_CNT_W = 4;
    localparam int unsigned PERF_CNT_W       = 16;

    typedef enum logic {
        S_CORE      = 1'b0,
        S_EXT_FORCE = 1'b1
    } arb_state_e;

    // Legal starvation limit: 1..15 and representable in the counter width.
    function automatic logic limit_fits(input int unsigned limit, input int unsigned cnt_w);
        return (limit >= 1) && (limit <= 15) && (64'(limit) < (64'(1) << cnt_w));
    endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Core, external-requester and memory-side signals around dmem_arbiter.
interface dmem_arb_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned WORD_W = DEF_WORD_W
) ();

    logic              in_core_load;
    logic              in_core_store;
    logic [ADDR_W-1:0] in_core_rd_addr;
    logic [ADDR_W-1:0] in_core_wr_addr;
    logic [WORD_W-1:0] in_core_wr_word;
    logic              out_core_stall;

    logic              in_ext_req_valid;
    logic              out_ext_req_ready;
    logic              in_ext_we;
    logic [ADDR_W-1:0] in_ext_addr;
    logic [WORD_W-1:0] in_ext_wdata;
    logic              out_ext_rdata_valid;
    logic [WORD_W-1:0] out_ext_rdata;

    logic              out_dmem_en;
    logic              out_dmem_we;
    logic [ADDR_W-1:0] out_dmem_addr;
    logic [WORD_W-1:0] out_dmem_wdata;
    logic [WORD_W-1:0] in_dmem_rdata;

    // Arbiter view
    modport slave (
        input  in_core_load, in_core_store, in_core_rd_addr, in_core_wr_addr, in_core_wr_word,
        output out_core_stall,
        input  in_ext_req_valid, in_ext_we, in_ext_addr, in_ext_wdata,
        output out_ext_req_ready, out_ext_rdata_valid, out_ext_rdata,
        output out_dmem_en, out_dmem_we, out_dmem_addr, out_dmem_wdata,
        input  in_dmem_rdata
    );

    // Surrounding pipeline / requester / memory view
    modport master (
        output in_core_load, in_core_store, in_core_rd_addr, in_core_wr_addr, in_core_wr_word,
        input  out_core_stall,
        output in_ext_req_valid, in_ext_we, in_ext_addr, in_ext_wdata,
        input  out_ext_req_ready, out_ext_rdata_valid, out_ext_rdata,
        input  out_dmem_en, out_dmem_we, out_dmem_addr, out_dmem_wdata,
        output in_dmem_rdata
    );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Counts consecutive cycles the external request is held off by the core; flags a forced grant.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned CNT_W        = DEF_STARVE_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic ext_valid,
    input  logic ext_blocked,
    output logic force_next_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any cycle the request is not held off (handshake or valid low) restarts the count
    always_comb begin
        cnt_d = '0;
        if (ext_valid && ext_blocked) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign force_next_c = (cnt_d == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: core has priority, external port gets a forced grant after STARVE_LIMIT waits.
// Optional performance counters enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DMEM_ADDR_WIDTH  = DEF_ADDR_W,
    parameter int unsigned DMEM_WORD_WIDTH  = DEF_WORD_W,
    parameter int unsigned STARVE_LIMIT     = DEF_STARVE_LIMIT,
    parameter int unsigned STARVE_CNT_WIDTH = DEF_STARVE_CNT_W
) (
    input  logic            clock,
    input  logic            reset,
    dmem_arb_if.slave       bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] out_perf_stall_cnt,
    output logic [PERF_CNT_W-1:0] out_perf_ext_cnt
`endif
);

    arb_state_e                 state_q;
    arb_state_e                 state_d;
    logic                       core_req;
    logic                       ext_blocked_c;
    logic                       force_next_c;
    logic                       en_c;
    logic                       we_c;
    logic [DMEM_ADDR_WIDTH-1:0] addr_c;
    logic [DMEM_WORD_WIDTH-1:0] wdata_c;
    logic                       ready_c;
    logic                       stall_c;
    logic                       ext_hs_c;
    logic                       rd_pending_q;
    logic                       rdata_valid_q;
    logic [DMEM_WORD_WIDTH-1:0] rdata_q;

    assign core_req      = bus.in_core_load | bus.in_core_store;
    // External request loses only to the core in normal state
    assign ext_blocked_c = (state_q == S_CORE) && core_req;
    assign ext_hs_c      = bus.in_ext_req_valid && ready_c;

    dmem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (STARVE_CNT_WIDTH)
    ) u_starve_ctr (
        .clock        (clock),
        .reset        (reset),
        .ext_valid    (bus.in_ext_req_valid),
        .ext_blocked  (ext_blocked_c),
        .force_next_c (force_next_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_CORE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and port muxing; everything is held at zero while reset is low
    always_comb begin
        state_d = S_CORE;
        en_c    = 1'b0;
        we_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        ready_c = 1'b0;
        stall_c = 1'b0;
        if (reset) begin
            case (state_q)
                S_CORE: begin
                    if (core_req) begin
                        // Store wins over a simultaneous load
                        en_c    = 1'b1;
                        we_c    = bus.in_core_store;
                        addr_c  = bus.in_core_store ? bus.in_core_wr_addr : bus.in_core_rd_addr;
                        wdata_c = bus.in_core_wr_word;
                    end else if (bus.in_ext_req_valid) begin
                        en_c    = 1'b1;
                        we_c    = bus.in_ext_we;
                        addr_c  = bus.in_ext_addr;
                        wdata_c = bus.in_ext_wdata;
                        ready_c = 1'b1;
                    end
                    if (force_next_c) begin
                        state_d = S_EXT_FORCE;
                    end
                end
                S_EXT_FORCE: begin
                    if (bus.in_ext_req_valid) begin
                        en_c    = 1'b1;
                        we_c    = bus.in_ext_we;
                        addr_c  = bus.in_ext_addr;
                        wdata_c = bus.in_ext_wdata;
                        ready_c = 1'b1;
                        stall_c = core_req;
                    end
                end
                default: state_d = S_CORE;
            endcase
        end
    end

    // External read return: capture memory data one cycle after the handshake
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_pending_q  <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
        end else begin
            rd_pending_q  <= ext_hs_c && !bus.in_ext_we;
            rdata_valid_q <= rd_pending_q;
            if (rd_pending_q) begin
                rdata_q <= bus.in_dmem_rdata;
            end
        end
    end

    assign bus.out_dmem_en         = en_c;
    assign bus.out_dmem_we         = we_c;
    assign bus.out_dmem_addr       = addr_c;
    assign bus.out_dmem_wdata      = wdata_c;
    assign bus.out_ext_req_ready   = ready_c;
    assign bus.out_core_stall      = stall_c;
    assign bus.out_ext_rdata_valid = rdata_valid_q;
    assign bus.out_ext_rdata       = rdata_q;

`ifdef DMEM_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] perf_stall_q;
    logic [PERF_CNT_W-1:0] perf_ext_q;

    // Stall count saturates, handshake count wraps
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_ext_q   <= '0;
        end else begin
            if (stall_c && (perf_stall_q != {PERF_CNT_W{1'b1}})) begin
                perf_stall_q <= perf_stall_q + PERF_CNT_W'(1);
            end
            if (ext_hs_c) begin
                perf_ext_q <= perf_ext_q + PERF_CNT_W'(1);
            end
        end
    end

    assign out_perf_stall_cnt = perf_stall_q;
    assign out_perf_ext_cnt   = perf_ext_q;
`endif

`ifndef SYNTHESIS
    a_limit_cfg: assert property (@(posedge clock) limit_fits(STARVE_LIMIT, STARVE_CNT_WIDTH))
        else $error("dmem_arbiter: STARVE_LIMIT out of range for STARVE_CNT_WIDTH");

    a_load_store: assert property (@(posedge clock) disable iff (!reset)
        !(bus.in_core_load && bus.in_core_store))
        else $warning("dmem_arbiter: core load and store asserted together, load dropped");

    a_ext_stable: assert property (@(posedge clock) disable iff (!reset)
        (bus.in_ext_req_valid && !ready_c) |=>
        (!bus.in_ext_req_valid || $stable({bus.in_ext_we, bus.in_ext_addr, bus.in_ext_wdata})))
        else $error("dmem_arbiter: external request changed while waiting");
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, directed multi-cycle sequences, randomized run vs. a reference model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned AW    = 12;
    localparam int unsigned WW    = 16;
    localparam int unsigned LIMIT = 4;
    localparam int unsigned CW    = 4;
    localparam int          NRAND = 1500;

    typedef struct {
        logic          ld;
        logic          st;
        logic [AW-1:0] rda;
        logic [AW-1:0] wra;
        logic [WW-1:0] wrw;
        logic          ev;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [WW-1:0] ewd;
        logic          x_en;
        logic          x_we;
        logic [AW-1:0] x_addr;
        logic [WW-1:0] x_wdata;
        logic          x_rdy;
        logic          x_stall;
    } vec_t;

    typedef struct {
        int            due;
        logic [WW-1:0] data;
    } rd_ret_t;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    dmem_arb_if #(.ADDR_W(AW), .WORD_W(WW)) bus ();

`ifdef DMEM_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] perf_stall;
    logic [PERF_CNT_W-1:0] perf_ext;
`endif

    dmem_arbiter #(
        .DMEM_ADDR_WIDTH  (AW),
        .DMEM_WORD_WIDTH  (WW),
        .STARVE_LIMIT     (LIMIT),
        .STARVE_CNT_WIDTH (CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef DMEM_ARB_PERF_EN
        ,
        .out_perf_stall_cnt (perf_stall),
        .out_perf_ext_cnt   (perf_ext)
`endif
    );

    // Synchronous single-port memory, 1-cycle read latency
    logic [WW-1:0] mem     [0:(1<<AW)-1];
    logic [WW-1:0] ref_mem [0:(1<<AW)-1];
    logic [WW-1:0] mem_rdata;

    always @(posedge clock) begin
        if (bus.out_dmem_en) begin
            if (bus.out_dmem_we) mem[bus.out_dmem_addr] <= bus.out_dmem_wdata;
            else                 mem_rdata <= mem[bus.out_dmem_addr];
        end
    end
    assign bus.in_dmem_rdata = mem_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_port(input string tag, input logic en, input logic we,
                            input logic [AW-1:0] addr, input logic [WW-1:0] wdata,
                            input logic rdy, input logic stl);
        chk({tag, ".en"},    32'(bus.out_dmem_en),       32'(en));
        chk({tag, ".we"},    32'(bus.out_dmem_we),       32'(we));
        chk({tag, ".addr"},  32'(bus.out_dmem_addr),     32'(addr));
        chk({tag, ".wdata"}, 32'(bus.out_dmem_wdata),    32'(wdata));
        chk({tag, ".ready"}, 32'(bus.out_ext_req_ready), 32'(rdy));
        chk({tag, ".stall"}, 32'(bus.out_core_stall),    32'(stl));
    endtask

    task automatic drive(input logic ld, input logic st, input logic [AW-1:0] rda,
                         input logic [AW-1:0] wra, input logic [WW-1:0] wrw,
                         input logic ev, input logic ewe, input logic [AW-1:0] ea,
                         input logic [WW-1:0] ewd);
        bus.in_core_load     = ld;
        bus.in_core_store    = st;
        bus.in_core_rd_addr  = rda;
        bus.in_core_wr_addr  = wra;
        bus.in_core_wr_word  = wrw;
        bus.in_ext_req_valid = ev;
        bus.in_ext_we        = ewe;
        bus.in_ext_addr      = ea;
        bus.in_ext_wdata     = ewd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_rv(input string name, input logic rv, input logic [WW-1:0] rd);
        chk({name, ".rvalid"}, 32'(bus.out_ext_rdata_valid), 32'(rv));
        if (rv) chk({name, ".rdata"}, 32'(bus.out_ext_rdata), 32'(rd));
    endtask

    initial begin
        vec_t          vecs [10];
        rd_ret_t       rq [$];
        rd_ret_t       ret;
        int            wait_cnt;
        int unsigned   r;
        logic          ld, st, ev, ewe, hold, creq, forced, exp_rv;
        logic [AW-1:0] rda, wra, ea;
        logic [WW-1:0] wrw, ewd;
        logic          x_en, x_we, x_rdy, x_stall;
        logic [AW-1:0] x_addr;
        logic [WW-1:0] x_wdata;

        //            ld    st    rda     wra     wrw       ev    ewe   ea      ewd       en    we    addr    wdata     rdy   stall
        vecs[0] = '{1'b0, 1'b1, 12'h000, 12'h010, 16'hBEEF, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h010, 16'hBEEF, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 12'h055, 12'h0AA, 16'h1111, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h055, 16'h1111, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 12'h055, 12'h0AA, 16'h1111, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h100, 16'hCAFE, 1'b1, 1'b1, 12'h100, 16'hCAFE, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h101, 16'h5A5A, 1'b1, 1'b0, 12'h101, 16'h5A5A, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 12'h200, 12'h201, 16'h2222, 1'b1, 1'b1, 12'h300, 16'h7777, 1'b1, 1'b0, 12'h200, 16'h2222, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 12'h200, 12'h201, 16'h2222, 1'b1, 1'b1, 12'h300, 16'h7777, 1'b1, 1'b1, 12'h300, 16'h7777, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 12'h123, 12'h3FF, 16'h0F0F, 1'b1, 1'b0, 12'h400, 16'h0000, 1'b1, 1'b1, 12'h3FF, 16'h0F0F, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 12'h000, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h400, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 12'h7FF, 12'h000, 16'h0001, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h7FF, 16'h0001, 1'b0, 1'b0};

        // Reset with requests present: outputs must stay zero
        reset = 1'b1;
        drive(1'b1, 1'b0, 12'h011, '0, '0, 1'b1, 1'b0, 12'h022, '0);
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_port("reset", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("reset.rvalid", 32'(bus.out_ext_rdata_valid), 32'd0);
        chk("reset.rdata",  32'(bus.out_ext_rdata),       32'd0);
        idle();
        #1 reset = 1'b1;
        advance();

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].ld, vecs[i].st, vecs[i].rda, vecs[i].wra, vecs[i].wrw,
                  vecs[i].ev, vecs[i].ewe, vecs[i].ea, vecs[i].ewd);
            @(negedge clock);
            chk_port($sformatf("vec%0d", i), vecs[i].x_en, vecs[i].x_we, vecs[i].x_addr,
                     vecs[i].x_wdata, vecs[i].x_rdy, vecs[i].x_stall);
            advance();
        end
        idle();
        advance();

        // External write then read back: data two cycles after the handshake
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 12'h020, 16'h1234);
        @(negedge clock); chk_port("a.wr", 1'b1, 1'b1, 12'h020, 16'h1234, 1'b1, 1'b0); advance();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 12'h020, 16'h0000);
        @(negedge clock); chk_port("a.rd", 1'b1, 1'b0, 12'h020, 16'h0000, 1'b1, 1'b0);
        chk_rv("a.c0", 1'b0, '0); advance();
        idle();
        @(negedge clock); chk_rv("a.c1", 1'b0, '0); advance();
        @(negedge clock); chk_rv("a.c2", 1'b1, 16'h1234); advance();
        @(negedge clock); chk_rv("a.c3", 1'b0, '0); advance();

        // Starvation: four refusals, then forced grant with one stall cycle
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 12'h060, '0, '0, 1'b1, 1'b1, 12'h050, 16'hABCD);
            @(negedge clock);
            if (i < 4) chk_port($sformatf("b.wait%0d", i), 1'b1, 1'b0, 12'h060, 16'h0000, 1'b0, 1'b0);
            else       chk_port("b.force", 1'b1, 1'b1, 12'h050, 16'hABCD, 1'b1, 1'b1);
            advance();
        end
        drive(1'b1, 1'b0, 12'h060, '0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clock); chk_port("b.resume", 1'b1, 1'b0, 12'h060, 16'h0000, 1'b0, 1'b0); advance();
        idle(); advance();

        // Forced-grant cycle with valid dropped and core idle, then normal priority again
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 12'h061, '0, '0, 1'b1, 1'b1, 12'h051, 16'h5151);
            advance();
        end
        idle();
        @(negedge clock); chk_port("c.drop", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0); advance();
        drive(1'b1, 1'b0, 12'h061, '0, '0, 1'b1, 1'b1, 12'h051, 16'h5151);
        @(negedge clock); chk_port("c.core", 1'b1, 1'b0, 12'h061, 16'h0000, 1'b0, 1'b0); advance();
        idle();
        @(negedge clock); chk_port("c.idle", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0); advance();

        // Load and store together: the store is performed
        drive(1'b1, 1'b1, 12'h070, 12'h071, 16'h4242, 1'b0, 1'b0, '0, '0);
        @(negedge clock); chk_port("d.ldst", 1'b1, 1'b1, 12'h071, 16'h4242, 1'b0, 1'b0); advance();
        idle(); advance();

        // Reset right after an external read handshake discards the return
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 12'h020, '0);
        @(negedge clock); chk_port("e.rd", 1'b1, 1'b0, 12'h020, 16'h0000, 1'b1, 1'b0); advance();
        reset = 1'b0;
        drive(1'b1, 1'b0, 12'h033, '0, '0, 1'b1, 1'b0, 12'h020, '0);
        @(negedge clock);
        chk_port("e.rst0", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("e.rst0.rvalid", 32'(bus.out_ext_rdata_valid), 32'd0);
        chk("e.rst0.rdata",  32'(bus.out_ext_rdata),       32'd0);
        advance();
        @(negedge clock);
        chk_port("e.rst1", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("e.rst1.rvalid", 32'(bus.out_ext_rdata_valid), 32'd0);
        idle();
        #1 reset = 1'b1;
        advance();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 12'h020, '0);
        @(negedge clock); chk_port("e.rd2", 1'b1, 1'b0, 12'h020, 16'h0000, 1'b1, 1'b0); advance();
        idle();
        @(negedge clock); chk_rv("e.c1", 1'b0, '0); advance();
        @(negedge clock); chk_rv("e.c2", 1'b1, 16'h1234); advance();
        advance();

        // Randomized contention against the reference model
        ref_mem  = mem;
        wait_cnt = 0;
        hold     = 1'b0;
        ewe = 1'b0; ea = '0; ewd = '0;
        for (int c = 0; c < NRAND; c++) begin
            r   = $urandom_range(0, 9);
            ld  = (r < 4);
            st  = (r >= 4) && (r < 7);
            rda = AW'($urandom_range(0, 31));
            wra = AW'($urandom_range(0, 31));
            wrw = WW'($urandom);
            if (hold) begin
                ev = ($urandom_range(0, 9) != 0);
            end else begin
                ev  = 1'($urandom_range(0, 1));
                ewe = 1'($urandom_range(0, 1));
                ea  = AW'($urandom_range(0, 31));
                ewd = WW'($urandom);
            end
            if (c >= NRAND - 4) begin
                ld = 1'b0; st = 1'b0; ev = 1'b0;
            end
            drive(ld, st, rda, wra, wrw, ev, ewe, ea, ewd);

            // Who owns the memory this cycle
            creq    = ld | st;
            forced  = (wait_cnt == int'(LIMIT));
            x_en = 1'b0; x_we = 1'b0; x_addr = '0; x_wdata = '0; x_rdy = 1'b0; x_stall = 1'b0;
            if (forced || !creq) begin
                if (ev) begin
                    x_en = 1'b1; x_we = ewe; x_addr = ea; x_wdata = ewd; x_rdy = 1'b1;
                    x_stall = forced && creq;
                end
                wait_cnt = 0;
            end else begin
                x_en = 1'b1; x_we = st; x_addr = st ? wra : rda; x_wdata = wrw;
                wait_cnt = ev ? wait_cnt + 1 : 0;
            end
            exp_rv = (rq.size() > 0) && (rq[0].due == c);

            @(negedge clock);
            chk_port($sformatf("rnd%0d", c), x_en, x_we, x_addr, x_wdata, x_rdy, x_stall);
            if (exp_rv) begin
                ret = rq.pop_front();
                chk_rv($sformatf("rnd%0d", c), 1'b1, ret.data);
            end else begin
                chk_rv($sformatf("rnd%0d", c), 1'b0, '0);
            end
            if (x_en && x_we) ref_mem[x_addr] = x_wdata;
            if (x_rdy && !ewe) rq.push_back('{c + 2, ref_mem[ea]});
            hold = ev && !x_rdy;
            advance();
        end
        chk("rnd.drain", 32'(rq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
